// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default frame geometry.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous inputs; both stages reset to RESET_VAL.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic system_clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge system_clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with valid/ready byte output, framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 system_clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   rxd_s;
    logic                   deliver;
    logic                   stop_bad;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .system_clk (system_clk),
        .reset      (reset),
        .d          (rxd),
        .q          (rxd_s)
    );

    always_ff @(posedge system_clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        deliver  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_tick && !rxd_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d = '0;
                        idx_d = '0;
                        // A high line at mid start bit means the falling edge was a glitch.
                        state_d = rxd_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        for (int unsigned i = 0; i < DATA_BITS; i++) begin
                            if (idx_q == IDX_W'(i)) shift_d[i] = rxd_s;
                        end
                        cnt_d = '0;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (sample_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (rxd_s) begin
                            deliver = 1'b1;
                            state_d = IDLE;
                        end else begin
                            stop_bad = 1'b1;
                            state_d  = WAIT_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rxd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= deliver && rx_valid && !rx_ready;
            // A same-cycle consume frees the slot, so the new byte replaces the old one.
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_q;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: tick every 4 clocks, 64-clock bit period, random frames vs a frame-level model.
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       system_clk = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Observation counters filled by the monitor
    int         valid_rises  = 0;
    int         valid_cycles = 0;
    int         fe_cycles    = 0;
    int         fe_pulses    = 0;
    int         ov_cycles    = 0;
    int         ov_pulses    = 0;
    logic       valid_prev   = 1'b0;
    logic       fe_prev      = 1'b0;
    logic       ov_prev      = 1'b0;
    logic [7:0] acc_q[$];

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .system_clk (system_clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 system_clk = ~system_clk;

    initial begin
        int div;
        div = 0;
        sample_tick = 1'b0;
        forever begin
            @(posedge system_clk);
            #1;
            sample_tick = (div == 3);
            div = (div + 1) % 4;
        end
    end

    always @(negedge system_clk) begin
        if (!reset) begin
            if (rx_valid && rx_ready) acc_q.push_back(rx_data);
            if (rx_valid && !valid_prev) valid_rises++;
            if (rx_valid) valid_cycles++;
            if (frame_err) fe_cycles++;
            if (frame_err && !fe_prev) fe_pulses++;
            if (overrun) ov_cycles++;
            if (overrun && !ov_prev) ov_pulses++;
        end
        valid_prev = rx_valid;
        fe_prev    = frame_err;
        ov_prev    = overrun;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge system_clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int n);
        rxd = b;
        wait_clks(n);
    endtask

    // Start bit, data LSB first, then stop level held for stop_len clocks (rxd left at stop level)
    task automatic send_frame(input logic [7:0] data, input logic stop_val, input int stop_len);
        send_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) send_bit(data[i], BIT_CLKS);
        send_bit(stop_val, stop_len);
    endtask

    task automatic test_reset();
        reset = 1'b1; rxd = 1'b1; rx_ready = 1'b0;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(1);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h required 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b required 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b required 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    endtask

    task automatic test_frame(input logic [7:0] data, input string name);
        int vc0, fe0, ov0;
        acc_q.delete();
        rx_ready = 1'b1;
        vc0 = valid_cycles; fe0 = fe_cycles; ov0 = ov_cycles;
        send_frame(data, 1'b1, BIT_CLKS);
        wait_clks(BIT_CLKS);
        checks++; if (valid_cycles - vc0 !== 1) begin errors++; $display("FAIL %s_valid_cycles: got %0d required 1", name, valid_cycles - vc0); end
        checks++;
        if (acc_q.size() !== 1) begin errors++; $display("FAIL %s_count: got %0d required 1", name, acc_q.size()); end
        else if (acc_q[0] !== data) begin errors++; $display("FAIL %s_data: got %h required %h", name, acc_q[0], data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b required 0", name, busy); end
        checks++; if (fe_cycles - fe0 !== 0 || ov_cycles - ov0 !== 0) begin
            errors++; $display("FAIL %s_err_pulses: got fe=%0d ov=%0d required 0 0", name, fe_cycles - fe0, ov_cycles - ov0); end
    endtask

    task automatic test_glitch();
        int vr0, fe0;
        vr0 = valid_rises; fe0 = fe_cycles;
        send_bit(1'b0, 16);
        send_bit(1'b1, BIT_CLKS);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b required 0", busy); end
        checks++; if (valid_rises - vr0 !== 0 || fe_cycles - fe0 !== 0) begin
            errors++; $display("FAIL glitch_output: got valid=%0d fe=%0d required 0 0", valid_rises - vr0, fe_cycles - fe0); end
    endtask

    task automatic test_frame_err();
        int vr0, fe0, fp0;
        acc_q.delete();
        rx_ready = 1'b1;
        vr0 = valid_rises; fe0 = fe_cycles; fp0 = fe_pulses;
        send_frame(8'h3C, 1'b0, 3 * BIT_CLKS);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_wait_idle_busy: got %b required 1", busy); end
        checks++; if (fe_pulses - fp0 !== 1 || fe_cycles - fe0 !== 1) begin
            errors++; $display("FAIL ferr_pulse: got pulses=%0d cycles=%0d required 1 1", fe_pulses - fp0, fe_cycles - fe0); end
        checks++; if (valid_rises - vr0 !== 0) begin errors++; $display("FAIL ferr_no_valid: got %0d required 0", valid_rises - vr0); end
        rxd = 1'b1;
        wait_clks(4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_exit_idle: got busy=%b required 0", busy); end
        wait_clks(BIT_CLKS);
        send_frame(8'h81, 1'b1, BIT_CLKS);
        wait_clks(BIT_CLKS);
        checks++;
        if (acc_q.size() !== 1) begin errors++; $display("FAIL ferr_next_count: got %0d required 1", acc_q.size()); end
        else if (acc_q[0] !== 8'h81) begin errors++; $display("FAIL ferr_next_data: got %h required 81", acc_q[0]); end
    endtask

    // Waits (bounded) until busy equals lvl; returns 0 on timeout
    task automatic wait_busy(input logic lvl, output bit ok);
        ok = 1'b1;
        for (int n = 0; n < 2000 && busy !== lvl; n++) wait_clks(1);
        if (busy !== lvl) ok = 1'b0;
    endtask

    task automatic test_back_to_back();
        int op0, oc0;
        bit ok1, ok2, ok3;
        // Overrun: consumer never ready
        acc_q.delete();
        rx_ready = 1'b0;
        op0 = ov_pulses; oc0 = ov_cycles;
        send_frame(8'h12, 1'b1, 48);
        send_frame(8'h34, 1'b1, BIT_CLKS);
        wait_clks(BIT_CLKS);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_ovr_valid: got %b required 1", rx_valid); end
        checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL b2b_ovr_data: got %h required 12", rx_data); end
        checks++; if (ov_pulses - op0 !== 1 || ov_cycles - oc0 !== 1) begin
            errors++; $display("FAIL b2b_ovr_pulse: got pulses=%0d cycles=%0d required 1 1", ov_pulses - op0, ov_cycles - oc0); end
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
        wait_clks(2);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_ovr_drain: got valid=%b required 0", rx_valid); end

        // Consume on exactly the second delivery cycle
        acc_q.delete();
        op0 = ov_pulses;
        fork
            begin
                send_frame(8'h12, 1'b1, 48);
                send_frame(8'h34, 1'b1, BIT_CLKS);
            end
            begin
                wait_busy(1'b1, ok1);
                wait_busy(1'b0, ok2);
                wait_busy(1'b1, ok3);
                // Stop sample lands 608 clocks after start detection
                wait_clks(607);
                rx_ready = 1'b1;
                wait_clks(1);
                rx_ready = 1'b0;
            end
        join
        wait_clks(BIT_CLKS);
        checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL b2b_busy_timeout: got %0b%0b%0b required 111", ok1, ok2, ok3); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h34) begin
            errors++; $display("FAIL b2b_swap_data: got valid=%b data=%h required 1 34", rx_valid, rx_data); end
        checks++; if (ov_pulses - op0 !== 0) begin errors++; $display("FAIL b2b_swap_overrun: got %0d required 0", ov_pulses - op0); end
        checks++;
        if (acc_q.size() !== 1) begin errors++; $display("FAIL b2b_swap_count: got %0d required 1", acc_q.size()); end
        else if (acc_q[0] !== 8'h12) begin errors++; $display("FAIL b2b_swap_first: got %h required 12", acc_q[0]); end
        rx_ready = 1'b1;
        wait_clks(2);
        checks++; if (acc_q.size() !== 2 || rx_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_swap_drain: got count=%0d valid=%b required 2 0", acc_q.size(), rx_valid); end
        else if (acc_q[1] !== 8'h34) begin errors++; $display("FAIL b2b_swap_second: got %h required 34", acc_q[1]); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int vr0, fe0;
        d = 8'hA5;
        rx_ready = 1'b1;
        send_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) send_bit(d[i], BIT_CLKS);
        send_bit(d[4], BIT_CLKS / 2);
        reset = 1'b1; rxd = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            errors++; $display("FAIL rst_mid_data: got valid=%b data=%h required 0 00", rx_valid, rx_data); end
        checks++; if (busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL rst_mid_flags: got busy=%b fe=%b ov=%b required 0 0 0", busy, frame_err, overrun); end
        vr0 = valid_rises; fe0 = fe_cycles;
        acc_q.delete();
        wait_clks(2 * BIT_CLKS);
        checks++; if (valid_rises - vr0 !== 0 || fe_cycles - fe0 !== 0) begin
            errors++; $display("FAIL rst_mid_quiet: got valid=%0d fe=%0d required 0 0", valid_rises - vr0, fe_cycles - fe0); end
        send_frame(8'hF0, 1'b1, BIT_CLKS);
        wait_clks(BIT_CLKS);
        checks++;
        if (acc_q.size() !== 1) begin errors++; $display("FAIL rst_next_count: got %0d required 1", acc_q.size()); end
        else if (acc_q[0] !== 8'hF0) begin errors++; $display("FAIL rst_next_data: got %h required F0", acc_q[0]); end
    endtask

    // Frame-level model: good stop -> byte delivered and consumed once; bad stop -> one framing error, no byte
    task automatic test_random();
        logic [7:0] exp_q[$];
        int exp_fe, fe0, ov0, vc0;
        logic [7:0] d;
        bit good;
        acc_q.delete();
        rx_ready = 1'b1;
        exp_fe = 0;
        fe0 = fe_pulses; ov0 = ov_pulses; vc0 = valid_cycles;
        for (int f = 0; f < 10; f++) begin
            d = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            if (good) begin
                send_frame(d, 1'b1, int'($urandom_range(48, 96)));
                exp_q.push_back(d);
            end else begin
                send_frame(d, 1'b0, int'($urandom_range(64, 192)));
                rxd = 1'b1;
                wait_clks(int'($urandom_range(8, 32)));
                exp_fe++;
            end
            wait_clks(int'($urandom_range(1, 64)));
        end
        wait_clks(BIT_CLKS);
        checks++; if (acc_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d required %0d", acc_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h required %h", i, acc_q[i], exp_q[i]); end
        end
        checks++; if (fe_pulses - fe0 !== exp_fe) begin errors++; $display("FAIL rand_frame_err: got %0d required %0d", fe_pulses - fe0, exp_fe); end
        checks++; if (ov_pulses - ov0 !== 0) begin errors++; $display("FAIL rand_overrun: got %0d required 0", ov_pulses - ov0); end
        checks++; if (valid_cycles - vc0 !== exp_q.size()) begin
            errors++; $display("FAIL rand_valid_cycles: got %0d required %0d", valid_cycles - vc0, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        wait_clks(BIT_CLKS);
        test_frame(8'h55, "frame55");
        test_frame(8'hA3, "frameA3");
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
